// File: rtl/hit_text_overlay.sv
// hit_text_overlay: floating "CRITICAL HIT" / "DESTROYED" text controller,
// one independent channel per tank.
//   frame_clk, Reset          frame clock, async active-high reset
//   hit, health               per-tank collision pulse and health sampled with it
//   tank_x/y, tank_x/y_motion per-tank position and signed per-frame step
//   draw_crit, draw_dest      per-channel draw flags (never both set)
//   text_x, text_y            per-channel text anchor
//   active, any_active        channel busy flags and their OR
// Every output is a flop.

module hit_text_lane #(
  parameter int HEALTH_W     = 4,
  parameter int SHOW_FRAMES  = 180,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_PERIOD = 8,
  parameter int RISE_PERIOD  = 6,
  parameter int OFFSET_X     = 34,
  parameter int OFFSET_Y     = 20,
  parameter bit STICKY_DEST  = 1'b1
) (
  input  logic                frame_clk,
  input  logic                Reset,
  input  logic                hit,
  input  logic [HEALTH_W-1:0] health,
  input  logic [9:0]          tank_x,
  input  logic [9:0]          tank_y,
  input  logic [9:0]          tank_x_motion,
  input  logic [9:0]          tank_y_motion,
  output logic                draw_crit,
  output logic                draw_dest,
  output logic [9:0]          text_x,
  output logic [9:0]          text_y,
  output logic                active,
  output logic                active_nxt
);
  localparam int CW = $clog2(SHOW_FRAMES + 1);
  localparam int RP = (RISE_PERIOD > 0) ? RISE_PERIOD : 1;
  localparam int RW = $clog2(RP + 1);
  localparam int BW = $clog2(BLINK_PERIOD + 1);
  localparam logic [CW-1:0] SHOW_END = CW'(SHOW_FRAMES - BLINK_FRAMES - 1);
  localparam logic [CW-1:0] LAST     = CW'(SHOW_FRAMES - 1);
  localparam logic [RW-1:0] RP_END   = RW'(RP - 1);
  localparam logic [BW-1:0] BP_END   = BW'(BLINK_PERIOD - 1);

  typedef enum logic [1:0] {IDLE, SHOW, BLINK, HOLD} state_t;

  state_t        st, st_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [RW-1:0] rcnt, rcnt_n;   // drift phase, mirrors cnt % RISE_PERIOD
  logic [BW-1:0] bcnt, bcnt_n;   // frames into current blink half-phase
  logic          vis, vis_n, dest, dest_n;
  logic [9:0]    tx_n, ty_n, tx_trk, ty_mv, ty_trk, ax, ay;
  logic          crit_n, dst_n;

  // Anchor clamps at 0 instead of wrapping when the tank is near the edge
  assign ax = (tank_x < 10'(OFFSET_X)) ? 10'd0 : tank_x - 10'(OFFSET_X);
  assign ay = (tank_y < 10'(OFFSET_Y)) ? 10'd0 : tank_y - 10'(OFFSET_Y);

  // Tracking wraps mod 1024; the upward drift alone saturates at 0
  assign tx_trk = text_x + tank_x_motion;
  assign ty_mv  = text_y + tank_y_motion;
  assign ty_trk = (RISE_PERIOD > 0 && rcnt == RP_END) ?
                  ((ty_mv == 10'd0) ? 10'd0 : ty_mv - 10'd1) : ty_mv;

  always_comb begin
    st_n = st; cnt_n = cnt; rcnt_n = rcnt; bcnt_n = bcnt;
    vis_n = vis; dest_n = dest; tx_n = text_x; ty_n = text_y;
    if (hit && st != HOLD) begin
      st_n = SHOW; cnt_n = '0; rcnt_n = '0; bcnt_n = '0; vis_n = 1'b1;
      dest_n = (health == '0);
      tx_n = ax; ty_n = ay;
    end else begin
      case (st)
        SHOW, BLINK: begin
          tx_n   = tx_trk;
          ty_n   = ty_trk;
          cnt_n  = cnt + 1'b1;
          rcnt_n = (rcnt == RP_END) ? '0 : rcnt + 1'b1;
          if (st == BLINK) begin
            if (bcnt == BP_END) begin
              bcnt_n = '0;
              vis_n  = ~vis;
            end else begin
              bcnt_n = bcnt + 1'b1;
            end
          end
          if ((st == SHOW && cnt == SHOW_END && BLINK_FRAMES == 0) ||
              (st == BLINK && cnt == LAST)) begin
            st_n = (dest && STICKY_DEST) ? HOLD : IDLE;
            cnt_n = '0; rcnt_n = '0; bcnt_n = '0;
          end else if (st == SHOW && cnt == SHOW_END) begin
            st_n = BLINK; bcnt_n = '0; vis_n = 1'b1;
          end
        end
        HOLD: begin
          tx_n = tx_trk;
          ty_n = ty_mv;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    crit_n     = ~dest_n & ((st_n == SHOW) | ((st_n == BLINK) & vis_n));
    dst_n      =  dest_n & ((st_n == SHOW) | ((st_n == BLINK) & vis_n) | (st_n == HOLD));
    active_nxt = (st_n != IDLE);
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      st <= IDLE; cnt <= '0; rcnt <= '0; bcnt <= '0; vis <= 1'b0; dest <= 1'b0;
      text_x <= '0; text_y <= '0;
      draw_crit <= 1'b0; draw_dest <= 1'b0; active <= 1'b0;
    end else begin
      st <= st_n; cnt <= cnt_n; rcnt <= rcnt_n; bcnt <= bcnt_n; vis <= vis_n; dest <= dest_n;
      text_x <= tx_n; text_y <= ty_n;
      draw_crit <= crit_n; draw_dest <= dst_n; active <= active_nxt;
    end
  end
endmodule

module hit_text_overlay #(
  parameter int NUM_TANKS    = 2,
  parameter int HEALTH_W     = 4,
  parameter int SHOW_FRAMES  = 180,
  parameter int BLINK_FRAMES = 60,
  parameter int BLINK_PERIOD = 8,
  parameter int RISE_PERIOD  = 6,
  parameter int OFFSET_X     = 34,
  parameter int OFFSET_Y     = 20,
  parameter bit STICKY_DEST  = 1'b1
) (
  input  logic                               frame_clk,
  input  logic                               Reset,
  input  logic [NUM_TANKS-1:0]               hit,
  input  logic [NUM_TANKS-1:0][HEALTH_W-1:0] health,
  input  logic [NUM_TANKS-1:0][9:0]          tank_x,
  input  logic [NUM_TANKS-1:0][9:0]          tank_y,
  input  logic [NUM_TANKS-1:0][9:0]          tank_x_motion,
  input  logic [NUM_TANKS-1:0][9:0]          tank_y_motion,
  output logic [NUM_TANKS-1:0]               draw_crit,
  output logic [NUM_TANKS-1:0]               draw_dest,
  output logic [NUM_TANKS-1:0][9:0]          text_x,
  output logic [NUM_TANKS-1:0][9:0]          text_y,
  output logic [NUM_TANKS-1:0]               active,
  output logic                               any_active
);
  logic [NUM_TANKS-1:0] active_nxt;

  for (genvar i = 0; i < NUM_TANKS; i++) begin : g_lane
    hit_text_lane #(
      .HEALTH_W(HEALTH_W), .SHOW_FRAMES(SHOW_FRAMES), .BLINK_FRAMES(BLINK_FRAMES),
      .BLINK_PERIOD(BLINK_PERIOD), .RISE_PERIOD(RISE_PERIOD),
      .OFFSET_X(OFFSET_X), .OFFSET_Y(OFFSET_Y), .STICKY_DEST(STICKY_DEST)
    ) u_lane (
      .frame_clk(frame_clk), .Reset(Reset), .hit(hit[i]), .health(health[i]),
      .tank_x(tank_x[i]), .tank_y(tank_y[i]),
      .tank_x_motion(tank_x_motion[i]), .tank_y_motion(tank_y_motion[i]),
      .draw_crit(draw_crit[i]), .draw_dest(draw_dest[i]),
      .text_x(text_x[i]), .text_y(text_y[i]),
      .active(active[i]), .active_nxt(active_nxt[i])
    );
  end

  // Built from next-state so it lines up with the per-channel active flops
  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) any_active <= 1'b0;
    else       any_active <= |active_nxt;
  end
endmodule
